// File: rtl/rn_recover_ctrl_pkg.sv
// rn_recover_ctrl_pkg: state encodings and derived group-index width for rename recovery
package rn_recover_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_ROLLBACK = 3'd2,
    S_COPY     = 3'd3,
    S_DONE     = 3'd4
  } state_e;
  function automatic int grp_w(input int lreg_aw, input int copy_per_cyc);
    return (lreg_aw > copy_per_cyc) ? lreg_aw - copy_per_cyc : 1;
  endfunction
endpackage

// File: rtl/rn_recover_ctrl.sv
// rn_recover_ctrl: flush recovery sequencer (drain, FL rollback, grouped RAT restore, ack) and rename stall
module rn_recover_ctrl
  import rn_recover_ctrl_pkg::*;
#(
  parameter int CONFIG_P_ISSUE_WIDTH = 1,
  parameter int P_LREG_AW            = 5,
  parameter int P_COPY_PER_CYC       = 2,
  localparam int GW                  = grp_w(P_LREG_AW, P_COPY_PER_CYC)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush_req,
  input  logic                                 cmt_idle,
  input  logic                                 fl_stall_req,
  output logic                                 fl_rollback,
  output logic                                 rat_copy_we,
  output logic [GW-1:0]                        rat_copy_grp,
  output logic [(1<<CONFIG_P_ISSUE_WIDTH)-1:0] rename_stall,
  output logic                                 flush_ack,
  output logic                                 busy
);
  localparam int NGRP = 1 << (P_LREG_AW - P_COPY_PER_CYC);
  localparam logic [GW-1:0] GRP_LAST = GW'(NGRP - 1);
  state_e        state_q;
  logic [GW-1:0] grp_q;
  logic          pend_q;
  logic          fl_rollback_q;
  logic          rat_copy_we_q;
  logic          flush_ack_q;
  // sequencer: state, group counter, pending-flush flag and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      grp_q         <= '0;
      pend_q        <= 1'b0;
      fl_rollback_q <= 1'b0;
      rat_copy_we_q <= 1'b0;
      flush_ack_q   <= 1'b0;
    end else begin
      pend_q <= (state_q == S_DONE) ? 1'b0 : pend_q | (flush_req & (state_q != S_IDLE));
      case (state_q)
        S_IDLE: begin
          if (flush_req) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (cmt_idle) begin
            state_q       <= S_ROLLBACK;
            fl_rollback_q <= 1'b1;
          end
        end
        S_ROLLBACK: begin
          state_q       <= S_COPY;
          fl_rollback_q <= 1'b0;
          rat_copy_we_q <= 1'b1;
          grp_q         <= '0;
        end
        S_COPY: begin
          grp_q <= (grp_q == GRP_LAST) ? '0 : grp_q + GW'(1);
          if (grp_q == GRP_LAST) begin
            state_q       <= S_DONE;
            rat_copy_we_q <= 1'b0;
            flush_ack_q   <= 1'b1;
          end
        end
        S_DONE: begin
          flush_ack_q <= 1'b0;
          state_q     <= (pend_q | flush_req) ? S_DRAIN : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign fl_rollback  = fl_rollback_q;
  assign rat_copy_we  = rat_copy_we_q;
  assign rat_copy_grp = grp_q;
  assign flush_ack    = flush_ack_q;
  assign busy         = state_q != S_IDLE;
  assign rename_stall = {(1<<CONFIG_P_ISSUE_WIDTH){busy | ((state_q == S_IDLE) & flush_req) | fl_stall_req}};
endmodule
